// File: rtl/sar_search_controller_pkg.sv
// Shared definitions for the successive-approximation search controller:
// FSM state encoding, default operand width and bit-index counter sizing.
package sar_search_controller_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrial = 2'd1,
        StDone  = 2'd2
    } sar_state_e;

    localparam int unsigned SAR_DEFAULT_N = 2;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_search_controller.sv
// MSB-first successive-approximation search: drives a trial value to an external
// "guess > target" comparator and converges on the target in N decisions.
module sar_search_controller
    import sar_search_controller_pkg::*;
#(
    parameter int unsigned N = SAR_DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         guess_greater_than_target,
    output logic [N-1:0] guess,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int unsigned IW = idx_width(N);

    sar_state_e    r_state, w_state_next;
    logic [N-1:0]  r_guess, w_guess_next;
    logic [N-1:0]  r_result, w_result_next;
    logic [IW-1:0] r_idx, w_idx_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic [N-1:0]  w_trial;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_guess  <= '0;
            r_result <= '0;
            r_idx    <= IW'(N - 1);
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_guess  <= w_guess_next;
            r_result <= w_result_next;
            r_idx    <= w_idx_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_guess_next  = r_guess;
        w_result_next = r_result;
        w_idx_next    = r_idx;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_trial       = r_guess;

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_guess_next        = '0;
                    w_guess_next[N-1]   = 1'b1;
                    w_idx_next          = IW'(N - 1);
                    w_busy_next         = 1'b1;
                    w_state_next        = StTrial;
                end else begin
                    w_busy_next  = 1'b0;
                    w_state_next = StIdle;
                end
            end
            StTrial: begin
                // Comparator says we overshot: drop the bit under test.
                if (guess_greater_than_target) begin
                    w_trial[r_idx] = 1'b0;
                end
                if (r_idx != '0) begin
                    w_trial[r_idx - IW'(1)] = 1'b1;
                    w_idx_next              = r_idx - IW'(1);
                end else begin
                    w_result_next = w_trial;
                    w_busy_next   = 1'b0;
                    w_done_next   = 1'b1;
                    w_state_next  = StDone;
                end
                w_guess_next = w_trial;
            end
            default: begin
                w_busy_next  = 1'b0;
                w_state_next = StIdle;
            end
        endcase
    end

    assign guess  = r_guess;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_sar_search_controller.sv
// Self-checking bench: N=2 and N=4 searches against a behavioural comparator and
// an arithmetic model of the expected trial sequence.
module tb_sar_search_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start2, start4;
    logic [1:0] tgt2;
    logic [3:0] tgt4;
    logic [1:0] guess2, result2;
    logic [3:0] guess4, result4;
    logic       busy2, done2, busy4, done4;
    logic       gt2, gt4;

    int compared = 0;
    int failed   = 0;

    // Behavioural greater-than comparator: A = guess, B = target.
    assign gt2 = (guess2 > tgt2);
    assign gt4 = (guess4 > tgt4);

    sar_search_controller #(.N(2)) u_dut2 (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start2),
        .guess_greater_than_target (gt2),
        .guess                     (guess2),
        .busy                      (busy2),
        .done                      (done2),
        .result                    (result2)
    );

    sar_search_controller #(.N(4)) u_dut4 (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start4),
        .guess_greater_than_target (gt4),
        .guess                     (guess4),
        .busy                      (busy4),
        .done                      (done4),
        .result                    (result4)
    );

    always #5 clk = ~clk;

    // Trial k (0-based) tests bit p = n-1-k: bits above p already equal the target's,
    // bit p is tentatively set, bits below are zero.
    function automatic int exp_guess(input int n, input int t, input int k);
        int p;
        p = n - 1 - k;
        return ((t >> (p + 1)) << (p + 1)) | (1 << p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start2 = 1'b0; start4 = 1'b0; tgt2 = '0; tgt4 = '0;
        #12;
        compared++;
        if ({guess4, result4, busy4, done4} !== 10'd0) begin
            failed++;
            $display("FAIL reset_n4: got g=%0d r=%0d b=%0b d=%0b want all 0",
                     guess4, result4, busy4, done4);
        end
        compared++;
        if ({guess2, result2, busy2, done2} !== 6'd0) begin
            failed++;
            $display("FAIL reset_n2: got g=%0d r=%0d b=%0b d=%0b want all 0",
                     guess2, result2, busy2, done2);
        end
        reset = 1'b0;
        tick();
    endtask

    // One N=4 search from IDLE; optionally re-pulses start during the trials.
    task automatic run4(input logic [3:0] t, input bit repulse);
        tgt4 = t; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (guess4 !== 4'(exp_guess(4, int'(t), k)) || busy4 !== 1'b1 || done4 !== 1'b0) begin
                failed++;
                $display("FAIL n4_trial t=%0d k=%0d: got g=%0d b=%0b d=%0b want g=%0d b=1 d=0",
                         t, k, guess4, busy4, done4, exp_guess(4, int'(t), k));
            end
            start4 = repulse && (k == 1 || k == 2);
            tick();
            start4 = 1'b0;
        end
        compared++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || result4 !== t || guess4 !== t) begin
            failed++;
            $display("FAIL n4_done t=%0d: got d=%0b b=%0b r=%0d g=%0d want d=1 b=0 r=g=%0d",
                     t, done4, busy4, result4, guess4, t);
        end
        tick();
        compared++;
        if (done4 !== 1'b0 || busy4 !== 1'b0 || result4 !== t) begin
            failed++;
            $display("FAIL n4_after t=%0d: got d=%0b b=%0b r=%0d want d=0 b=0 r=%0d",
                     t, done4, busy4, result4, t);
        end
    endtask

    task automatic test_n2_basic();
        tgt2 = 2'd2; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        compared++;
        if (guess2 !== 2'd2 || busy2 !== 1'b1) begin
            failed++;
            $display("FAIL n2_trial0: got g=%0d b=%0b want g=2 b=1", guess2, busy2);
        end
        tick();
        compared++;
        if (guess2 !== 2'd3 || busy2 !== 1'b1 || done2 !== 1'b0) begin
            failed++;
            $display("FAIL n2_trial1: got g=%0d b=%0b d=%0b want g=3 b=1 d=0",
                     guess2, busy2, done2);
        end
        tick();
        compared++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || result2 !== 2'd2) begin
            failed++;
            $display("FAIL n2_done: got d=%0b b=%0b r=%0d want d=1 b=0 r=2", done2, busy2, result2);
        end
        tick();
        compared++;
        if (done2 !== 1'b0 || result2 !== 2'd2) begin
            failed++;
            $display("FAIL n2_pulse: got d=%0b r=%0d want d=0 r=2", done2, result2);
        end
    endtask

    task automatic test_directed4();
        run4(4'd9, 1'b0);
        run4(4'd0, 1'b0);
        run4(4'd15, 1'b0);
    endtask

    task automatic test_restart_ignored();
        run4(4'd6, 1'b1);
        run4(4'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic test_random4();
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int j = 0; j < gap; j++) tick();
            run4(4'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    // start held high: every run must begin the cycle after done, no idle gap.
    task automatic test_back_to_back(input int n, input bit rnd);
        int runs, t;
        runs = rnd ? 6 : (1 << n);
        t = rnd ? int'($urandom_range(0, (1 << n) - 1)) : 0;
        if (n == 2) begin tgt2 = 2'(t); start2 = 1'b1; end
        else        begin tgt4 = 4'(t); start4 = 1'b1; end
        tick();
        for (int r = 0; r < runs; r++) begin
            for (int k = 0; k < n; k++) begin
                compared++;
                if (n == 2 ? (guess2 !== 2'(exp_guess(2, t, k)) || busy2 !== 1'b1)
                           : (guess4 !== 4'(exp_guess(4, t, k)) || busy4 !== 1'b1)) begin
                    failed++;
                    $display("FAIL b2b_trial n=%0d t=%0d k=%0d: got g=%0d b=%0b want g=%0d b=1",
                             n, t, k, (n == 2) ? int'(guess2) : int'(guess4),
                             (n == 2) ? busy2 : busy4, exp_guess(n, t, k));
                end
                tick();
            end
            compared++;
            if (n == 2 ? (done2 !== 1'b1 || busy2 !== 1'b0 || result2 !== 2'(t))
                       : (done4 !== 1'b1 || busy4 !== 1'b0 || result4 !== 4'(t))) begin
                failed++;
                $display("FAIL b2b_done n=%0d t=%0d: got d=%0b b=%0b r=%0d want d=1 b=0 r=%0d",
                         n, t, (n == 2) ? done2 : done4, (n == 2) ? busy2 : busy4,
                         (n == 2) ? int'(result2) : int'(result4), t);
            end
            // Target may change while in DONE: the comparator is not sampled there.
            t = rnd ? int'($urandom_range(0, (1 << n) - 1)) : r + 1;
            if (r == runs - 1) begin start2 = 1'b0; start4 = 1'b0; end
            if (n == 2) tgt2 = 2'(t); else tgt4 = 4'(t);
            tick();
        end
        compared++;
        if (n == 2 ? (busy2 !== 1'b0 || done2 !== 1'b0) : (busy4 !== 1'b0 || done4 !== 1'b0)) begin
            failed++;
            $display("FAIL b2b_idle n=%0d: got b=%0b d=%0b want b=0 d=0", n,
                     (n == 2) ? busy2 : busy4, (n == 2) ? done2 : done4);
        end
    endtask

    task automatic test_async_reset();
        run4(4'd13, 1'b0);
        tgt4 = 4'($urandom_range(0, 15)); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        #3 reset = 1'b1;
        #1;
        compared++;
        if ({guess4, result4, busy4, done4} !== 10'd0) begin
            failed++;
            $display("FAIL async_reset: got g=%0d r=%0d b=%0b d=%0b want all 0",
                     guess4, result4, busy4, done4);
        end
        #2 reset = 1'b0;
        tick();
        compared++;
        if (guess4 !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            failed++;
            $display("FAIL post_reset_idle: got g=%0d b=%0b d=%0b want 0 0 0",
                     guess4, busy4, done4);
        end
        run4(4'($urandom_range(0, 15)), 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_n2_basic();
        test_directed4();
        test_restart_ignored();
        test_random4();
        test_back_to_back(2, 1'b0);
        test_back_to_back(4, 1'b0);
        test_back_to_back(4, 1'b1);
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
